// File: rtl/column_fetch_scheduler_if.sv
// Angle request, frame-buffer read port and pixel stream of the column fetch scheduler.
interface column_fetch_scheduler_if #(
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned ROW_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ANGLE_WIDTH = 7
);
    logic                   angle_valid;
    logic [ANGLE_WIDTH-1:0] angle;
    logic                   r_en;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [ROW_WIDTH-1:0]   out_row;
    logic [1:0]             out_color;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    // Scheduler side
    modport master (
        input  angle_valid, angle, r_data, out_ready,
        output r_en, r_addr, out_data, out_valid, out_row, out_color, out_last,
               busy, done, overrun
    );

    // Environment side (rotor sensor, frame buffer, serializer)
    modport slave (
        output angle_valid, angle, r_data, out_ready,
        input  r_en, r_addr, out_data, out_valid, out_row, out_color, out_last,
               busy, done, overrun
    );
endinterface

// File: rtl/column_fetch_scheduler.sv
// Reads one LED column (all rows x 3 colours) from the frame buffer per angle
// request and streams the bytes to the serializer. One-deep request buffer.
module column_fetch_scheduler #(
    parameter int unsigned PCB_ANGLE  = 0,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned ROW_WIDTH  = 5,
    parameter int unsigned NB_ROWS    = 30,
    parameter int unsigned NB_ANGLES  = 128,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                      clk,
    input logic                      nrst,
    column_fetch_scheduler_if.master bus
);
    localparam int unsigned ANGLE_WIDTH = $clog2(NB_ANGLES);
    // Moving from colour 2 of one row to colour 0 of the next row
    localparam logic [ADDR_WIDTH-1:0]  ROW_STEP = ADDR_WIDTH'(3 * NB_ANGLES - 2);
    localparam logic [ROW_WIDTH-1:0]   LAST_ROW = ROW_WIDTH'(NB_ROWS - 1);
    localparam logic [ANGLE_WIDTH-1:0] PCB_OFS  = ANGLE_WIDTH'(PCB_ANGLE % NB_ANGLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [1:0]             color_q, color_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [ANGLE_WIDTH-1:0] pend_angle_q, pend_angle_d;
    logic                   r_en_q, r_en_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;

    logic                   start;
    logic [ANGLE_WIDTH-1:0] start_angle;
    logic [ANGLE_WIDTH-1:0] abs_angle;
    logic [DATA_WIDTH-1:0]  out_data_c;

    // Next-state, index/address walk, request buffer and registered outputs
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        color_d      = color_q;
        addr_d       = addr_q;
        pend_valid_d = pend_valid_q;
        pend_angle_d = pend_angle_q;
        done_d       = 1'b0;
        overrun_d    = 1'b0;
        start        = 1'b0;
        start_angle  = bus.angle;

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    start        = 1'b1;
                    start_angle  = pend_angle_q;
                    pend_valid_d = 1'b0;
                end else if (bus.angle_valid) begin
                    start = 1'b1;
                end
            end
            FETCH: begin
                state_d = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        if (color_q == 2'd2) begin
                            color_d = 2'd0;
                            row_d   = ROW_WIDTH'(row_q + 1'b1);
                            addr_d  = addr_q + ROW_STEP;
                        end else begin
                            color_d = 2'(color_q + 2'd1);
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Power-of-two angle count: the add wraps modulo NB_ANGLES by width
        abs_angle = start_angle + PCB_OFS;
        if (start) begin
            state_d = FETCH;
            row_d   = '0;
            color_d = 2'd0;
            addr_d  = ADDR_WIDTH'(abs_angle) + ADDR_WIDTH'({abs_angle, 1'b0});
        end

        // A request that cannot start this cycle lands in the one-deep buffer
        if (bus.angle_valid && ((state_q != IDLE) || pend_valid_q)) begin
            pend_angle_d = bus.angle;
            pend_valid_d = 1'b1;
            overrun_d    = pend_valid_q;
        end

        r_en_d      = (state_d == FETCH);
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d != IDLE);
        out_last_d  = (state_d == SEND) && (row_d == LAST_ROW) && (color_d == 2'd2);
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            color_q      <= 2'd0;
            addr_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_angle_q <= '0;
            r_en_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            color_q      <= color_d;
            addr_q       <= addr_d;
            pend_valid_q <= pend_valid_d;
            pend_angle_q <= pend_angle_d;
            r_en_q       <= r_en_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    // RAM holds r_data while r_en is low, so the byte is forwarded straight through
    assign out_data_c = out_valid_q ? bus.r_data : '0;

    assign bus.r_en      = r_en_q;
    assign bus.r_addr    = addr_q;
    assign bus.out_data  = out_data_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = row_q;
    assign bus.out_color = color_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_column_fetch_scheduler.sv
// Directed bench for column_fetch_scheduler with a RAM model and byte scoreboard.
module tb_column_fetch_scheduler;
    localparam int NB_ROWS   = 30;
    localparam int NB_ANGLES = 128;
    localparam int BYTES     = 3 * NB_ROWS;

    typedef struct {
        int addr;
        int row;
        int color;
        int last;
    } exp_t;

    logic       clk  = 1'b0;
    logic       nrst = 1'b0;
    logic       av   = 1'b0;
    logic       sel  = 1'b0;
    logic       rdy  = 1'b1;
    logic [6:0] ang  = '0;
    logic [7:0] rdata0 = '0;
    logic [7:0] rdata1 = '0;

    int total = 0;
    int bad   = 0;
    int ren_cnt = 0, hs_cnt = 0, done_cnt = 0, ov_cnt = 0;
    int done_due = 0;
    int hold_v = 0;
    logic [31:0] hold_data, hold_row, hold_color;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    column_fetch_scheduler_if #(.ADDR_WIDTH(14), .ROW_WIDTH(5), .DATA_WIDTH(8), .ANGLE_WIDTH(7)) if0 ();
    column_fetch_scheduler_if #(.ADDR_WIDTH(14), .ROW_WIDTH(5), .DATA_WIDTH(8), .ANGLE_WIDTH(7)) if1 ();

    column_fetch_scheduler #(.PCB_ANGLE(0)) dut0 (.clk(clk), .nrst(nrst), .bus(if0));
    column_fetch_scheduler #(.PCB_ANGLE(100)) dut1 (.clk(clk), .nrst(nrst), .bus(if1));

    assign if0.angle_valid = av & ~sel;
    assign if1.angle_valid = av & sel;
    assign if0.angle       = ang;
    assign if1.angle       = ang;
    assign if0.out_ready   = rdy;
    assign if1.out_ready   = rdy;
    assign if0.r_data      = rdata0;
    assign if1.r_data      = rdata1;

    function automatic logic [7:0] ram_word(input int a);
        return 8'((a * 37) ^ (a >> 5));
    endfunction

    function automatic int addr_of(input int abs_a, input int row, input int col);
        return col + 3 * abs_a + 3 * NB_ANGLES * row;
    endfunction

    // Frame-buffer model: data appears the cycle after r_en and is held otherwise
    always @(posedge clk) begin
        if (if0.r_en) rdata0 <= ram_word(int'(if0.r_addr));
        if (if1.r_en) rdata1 <= ram_word(int'(if1.r_addr));
    end

    // Observed DUT (sel picks the PCB_ANGLE=100 instance)
    logic [31:0] m_r_en, m_r_addr, m_out_data, m_out_valid, m_out_row, m_out_color;
    logic [31:0] m_out_last, m_busy, m_done, m_overrun;
    assign m_r_en      = 32'(sel ? if1.r_en      : if0.r_en);
    assign m_r_addr    = 32'(sel ? if1.r_addr    : if0.r_addr);
    assign m_out_data  = 32'(sel ? if1.out_data  : if0.out_data);
    assign m_out_valid = 32'(sel ? if1.out_valid : if0.out_valid);
    assign m_out_row   = 32'(sel ? if1.out_row   : if0.out_row);
    assign m_out_color = 32'(sel ? if1.out_color : if0.out_color);
    assign m_out_last  = 32'(sel ? if1.out_last  : if0.out_last);
    assign m_busy      = 32'(sel ? if1.busy      : if0.busy);
    assign m_done      = 32'(sel ? if1.done      : if0.done);
    assign m_overrun   = 32'(sel ? if1.overrun   : if0.overrun);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic push_sweep(input int a, input int pcb);
        int abs_a;
        abs_a = (a + pcb) % NB_ANGLES;
        for (int r = 0; r < NB_ROWS; r++) begin
            for (int c = 0; c < 3; c++) begin
                exp_t e;
                e.addr  = addr_of(abs_a, r, c);
                e.row   = r;
                e.color = c;
                e.last  = (r == NB_ROWS - 1 && c == 2) ? 1 : 0;
                exp_q.push_back(e);
            end
        end
    endtask

    // Samples the upcoming clock edge: read addresses, handshakes, stalls, done
    task automatic monitor();
        exp_t e;
        if (!nrst) begin
            exp_q.delete();
            hold_v   = 0;
            done_due = 0;
            ren_cnt  = hs_cnt;
            return;
        end
        check_val("done_pulse", m_done, 32'(done_due));
        done_due = 0;
        if (m_done == 1) done_cnt++;
        if (m_overrun == 1) ov_cnt++;
        if (hold_v != 0) begin
            check_val("stall_valid", m_out_valid, 1);
            check_val("stall_data", m_out_data, hold_data);
            check_val("stall_row", m_out_row, hold_row);
            check_val("stall_color", m_out_color, hold_color);
        end
        if (m_r_en == 1) begin
            ren_cnt++;
            check_val("ren_once", 32'(ren_cnt), 32'(hs_cnt + 1));
            check_val("raddr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_val("r_addr", m_r_addr, 32'(exp_q[0].addr));
        end
        if (m_out_valid == 1 && rdy) begin
            check_val("byte_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("out_data", m_out_data, 32'(ram_word(e.addr)));
                check_val("out_row", m_out_row, 32'(e.row));
                check_val("out_color", m_out_color, 32'(e.color));
                check_val("out_last", m_out_last, 32'(e.last));
                hs_cnt++;
                if (e.last != 0) done_due = 1;
            end
        end
        hold_v     = (m_out_valid == 1 && !rdy) ? 1 : 0;
        hold_data  = m_out_data;
        hold_row   = m_out_row;
        hold_color = m_out_color;
    endtask

    // One clock: check at the falling edge, return just after the rising edge
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int a);
        av  = 1'b1;
        ang = 7'(a);
        tick();
        av  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && m_busy == 0) break;
            tick();
        end
        check_val("idle_reached", 32'(exp_q.size() == 0 && m_busy == 0), 1);
        tick();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_r_en"}, m_r_en, 0);
        check_val({tag, "_r_addr"}, m_r_addr, 0);
        check_val({tag, "_out_valid"}, m_out_valid, 0);
        check_val({tag, "_out_data"}, m_out_data, 0);
        check_val({tag, "_out_row"}, m_out_row, 0);
        check_val({tag, "_out_color"}, m_out_color, 0);
        check_val({tag, "_out_last"}, m_out_last, 0);
        check_val({tag, "_busy"}, m_busy, 0);
        check_val({tag, "_done"}, m_done, 0);
        check_val({tag, "_overrun"}, m_overrun, 0);
    endtask

    initial begin
        int n, ren0, hs0, d0, ov0, stall;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        nrst = 1'b1;
        tick();

        // Basic sweep, angle 5, latency and sweep length
        push_sweep(5, 0);
        d0 = done_cnt;
        pulse(5);
        check_val("lat_r_en", m_r_en, 1);
        check_val("lat_valid_c1", m_out_valid, 0);
        check_val("first_addr", m_r_addr, 15);
        n = 1;
        tick();
        check_val("lat_valid_c2", m_out_valid, 1);
        check_val("lat_r_en_c2", m_r_en, 0);
        while (m_busy == 1 && n < 1000) begin
            n++;
            tick();
        end
        check_val("sweep_cycles", 32'(n), 32'(6 * NB_ROWS));
        check_val("last_addr", m_r_addr, 11153);
        wait_idle();
        check_val("done_count", 32'(done_cnt - d0), 1);

        // Angle wrap on the PCB_ANGLE=100 instance
        sel = 1'b1;
        push_sweep(40, 100);
        pulse(40);
        check_val("wrap_first_addr", m_r_addr, 36);
        wait_idle();
        check_val("wrap_last_addr", m_r_addr, 32'(addr_of(12, NB_ROWS - 1, 2)));
        sel = 1'b0;
        tick();

        // Random backpressure
        ren0 = ren_cnt;
        hs0  = hs_cnt;
        push_sweep(77, 0);
        pulse(77);
        stall = 0;
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && m_busy == 0) break;
            if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else begin
                rdy = 1'b1;
                if ($urandom_range(0, 2) == 0) stall = int'($urandom_range(1, 5));
            end
            tick();
        end
        rdy = 1'b1;
        wait_idle();
        check_val("bp_ren_count", 32'(ren_cnt - ren0), 32'(BYTES));
        check_val("bp_byte_count", 32'(hs_cnt - hs0), 32'(BYTES));

        // Pending buffer and overrun: 2 is replaced by 3
        ov0 = ov_cnt;
        d0  = done_cnt;
        push_sweep(1, 0);
        push_sweep(3, 0);
        pulse(1);
        repeat (10) tick();
        pulse(2);
        repeat (5) tick();
        pulse(3);
        wait_idle();
        check_val("overrun_count", 32'(ov_cnt - ov0), 1);
        check_val("pend_done_count", 32'(done_cnt - d0), 2);

        // Request on the final-handshake cycle: exactly one IDLE cycle
        push_sweep(7, 0);
        push_sweep(8, 0);
        pulse(7);
        for (int i = 0; i < 1000; i++) begin
            if (m_out_valid == 1 && m_out_last == 1) break;
            tick();
        end
        check_val("final_seen", m_out_last, 1);
        av  = 1'b1;
        ang = 7'd8;
        tick();
        av  = 1'b0;
        check_val("gap_idle", m_busy, 0);
        tick();
        check_val("gap_restart_busy", m_busy, 1);
        check_val("gap_restart_r_en", m_r_en, 1);
        check_val("gap_restart_addr", m_r_addr, 24);
        wait_idle();

        // Asynchronous reset mid-sweep discards the pending request
        hs0 = hs_cnt;
        push_sweep(20, 0);
        pulse(20);
        for (int i = 0; i < 1000; i++) begin
            if (hs_cnt - hs0 >= 20) break;
            tick();
        end
        check_val("pre_reset_bytes", 32'(hs_cnt - hs0 >= 20), 1);
        pulse(21);
        repeat (3) tick();
        nrst = 1'b0;
        #1;
        check_zero("midreset");
        tick();
        tick();
        nrst = 1'b1;
        ren0 = ren_cnt;
        repeat (5) tick();
        check_val("pend_discarded_busy", m_busy, 0);
        check_val("pend_discarded_ren", 32'(ren_cnt - ren0), 0);
        push_sweep(9, 0);
        pulse(9);
        check_val("post_reset_addr", m_r_addr, 27);
        check_val("post_reset_row", m_out_row, 0);
        check_val("post_reset_color", m_out_color, 0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
